// File: rtl/mipi_tx_frame_sched_if.sv
// ============================================================================
// Module      : mipi_tx_frame_sched_if
// Description : Pixel source handshake and MIPI TX video bus bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mipi_tx_frame_sched_if;
    logic [63:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic        tx_vsync;
    logic        tx_hsync;
    logic        tx_valid;
    logic [63:0] tx_data;

    // master: the scheduler; slave: pixel source plus MIPI TX sink
    modport master (
        input  src_data,
        input  src_valid,
        output src_ready,
        output tx_vsync,
        output tx_hsync,
        output tx_valid,
        output tx_data
    );

    modport slave (
        output src_data,
        output src_valid,
        input  src_ready,
        input  tx_vsync,
        input  tx_hsync,
        input  tx_valid,
        input  tx_data
    );
endinterface

`default_nettype wire

// File: rtl/mipi_tx_frame_sched.sv
// ============================================================================
// Module      : mipi_tx_frame_sched
// Description : MIPI TX frame/line timing scheduler: releases the TX core
//               reset, then sequences VSYNC/HSYNC/VALID and forwards beats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mipi_tx_frame_sched #(
    parameter int HRES_PX     = 600,
    parameter int PX_PER_BEAT = 6,
    parameter int LINES       = 480,
    parameter int RSTN_DLY    = 1000,
    parameter int VS_LEAD     = 2,
    parameter int HS_LEAD     = 98,
    parameter int HS_TAIL     = 100,
    parameter int LINE_GAP    = 1,
    parameter int FRAME_GAP   = 10000
) (
    input  wire logic              tx_pixel_clk,
    input  wire logic              rst,
    input  wire logic              enable,
    input  wire logic              underrun_clr,
    mipi_tx_frame_sched_if.master  bus,
    output logic                   tx_rstn,
    output logic                   busy,
    output logic                   frame_done,
    output logic [15:0]            frame_cnt,
    output logic                   underrun
);

    localparam int              c_BEATS      = HRES_PX / PX_PER_BEAT;
    localparam int              c_RCW        = (RSTN_DLY > 1) ? $clog2(RSTN_DLY) : 1;
    localparam logic [c_RCW-1:0] c_RSTN_LAST = c_RCW'(RSTN_DLY - 1);
    localparam logic [15:0]     c_VS_LAST    = 16'(VS_LEAD - 1);
    localparam logic [15:0]     c_HL_LAST    = 16'(HS_LEAD - 1);
    localparam logic [15:0]     c_BEAT_LAST  = 16'(c_BEATS - 1);
    localparam logic [15:0]     c_HT_LAST    = 16'(HS_TAIL - 1);
    localparam logic [15:0]     c_LG_LAST    = 16'(LINE_GAP - 1);
    localparam logic [15:0]     c_FG_LAST    = 16'(FRAME_GAP - 1);
    localparam logic [15:0]     c_LINE_LAST  = 16'(LINES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_VS_LEAD   = 3'd1,
        ST_HS_LEAD   = 3'd2,
        ST_ACTIVE    = 3'd3,
        ST_HS_TAIL   = 3'd4,
        ST_LINE_GAP  = 3'd5,
        ST_FRAME_GAP = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [15:0]        r_cyc_cnt;
    logic [15:0]        r_line_cnt;
    logic [c_RCW-1:0]   r_rstn_cnt;
    logic               r_tx_rstn;
    logic               r_tx_vsync;
    logic               r_tx_hsync;
    logic               r_tx_valid;
    logic [63:0]        r_tx_data;
    logic               r_frame_done;
    logic [15:0]        r_frame_cnt;
    logic               r_underrun;
    logic               w_line_clr;
    logic               w_line_adv;
    logic               w_frame_end;
    logic               w_src_ready;
    logic               w_vsync;
    logic               w_hsync;

    // TX core reset release: counts cycles since rst deasserted, then latches high
    always_ff @(posedge tx_pixel_clk) begin
        if (rst) begin
            r_rstn_cnt <= '0;
            r_tx_rstn  <= 1'b0;
        end else if (!r_tx_rstn) begin
            if (r_rstn_cnt == c_RSTN_LAST) begin
                r_tx_rstn <= 1'b1;
            end else begin
                r_rstn_cnt <= r_rstn_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge tx_pixel_clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_line_clr   = 1'b0;
        w_line_adv   = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && r_tx_rstn) w_state_next = ST_VS_LEAD;
            end
            ST_VS_LEAD: begin
                if (r_cyc_cnt == c_VS_LAST) begin
                    w_state_next = ST_HS_LEAD;
                    w_line_clr   = 1'b1;
                end
            end
            ST_HS_LEAD: begin
                if (r_cyc_cnt == c_HL_LAST) w_state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (r_cyc_cnt == c_BEAT_LAST) w_state_next = ST_HS_TAIL;
            end
            ST_HS_TAIL: begin
                if (r_cyc_cnt == c_HT_LAST) w_state_next = ST_LINE_GAP;
            end
            ST_LINE_GAP: begin
                if (r_cyc_cnt == c_LG_LAST) begin
                    if (r_line_cnt < c_LINE_LAST) begin
                        w_state_next = ST_HS_LEAD;
                        w_line_adv   = 1'b1;
                    end else begin
                        w_state_next = ST_FRAME_GAP;
                    end
                end
            end
            ST_FRAME_GAP: begin
                if (r_cyc_cnt == c_FG_LAST) begin
                    w_frame_end  = 1'b1;
                    w_state_next = enable ? ST_VS_LEAD : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Dwell counter restarts on every state change so each state holds exactly N cycles
    always_ff @(posedge tx_pixel_clk) begin
        if (rst || (w_state_next != r_state) || (r_state == ST_IDLE)) begin
            r_cyc_cnt <= '0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 16'd1;
        end
    end

    always_ff @(posedge tx_pixel_clk) begin
        if (rst || w_line_clr) begin
            r_line_cnt <= '0;
        end else if (w_line_adv) begin
            r_line_cnt <= r_line_cnt + 16'd1;
        end
    end

    assign w_src_ready = (r_state == ST_ACTIVE);
    assign w_vsync     = (r_state inside {ST_VS_LEAD, ST_HS_LEAD, ST_ACTIVE, ST_HS_TAIL, ST_LINE_GAP});
    assign w_hsync     = (r_state inside {ST_HS_LEAD, ST_ACTIVE, ST_HS_TAIL});

    always_ff @(posedge tx_pixel_clk) begin
        if (rst) begin
            r_tx_vsync   <= 1'b0;
            r_tx_hsync   <= 1'b0;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= '0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
            r_underrun   <= 1'b0;
        end else begin
            r_tx_vsync   <= w_vsync;
            r_tx_hsync   <= w_hsync;
            r_tx_valid   <= w_src_ready;
            r_frame_done <= w_frame_end;
            // A missing beat is sent as zeros so the line length stays fixed
            if (w_src_ready) begin
                r_tx_data <= bus.src_valid ? bus.src_data : 64'h0;
            end
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            r_underrun <= (w_src_ready && !bus.src_valid) || (r_underrun && !underrun_clr);
        end
    end

    assign bus.src_ready = w_src_ready;
    assign bus.tx_vsync  = r_tx_vsync;
    assign bus.tx_hsync  = r_tx_hsync;
    assign bus.tx_valid  = r_tx_valid;
    assign bus.tx_data   = r_tx_data;
    assign tx_rstn       = r_tx_rstn;
    assign busy          = (r_state != ST_IDLE);
    assign frame_done    = r_frame_done;
    assign frame_cnt     = r_frame_cnt;
    assign underrun      = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_mipi_tx_frame_sched.sv
// ============================================================================
// Module      : tb_mipi_tx_frame_sched
// Description : Self-checking bench for mipi_tx_frame_sched with a beat scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mipi_tx_frame_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        underrun_clr = 1'b0;
    logic        tx_rstn;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        underrun;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_beats = 0;
    int          beat_idx = 0;
    logic [31:0] drop_mask = 32'h0;
    int          cyc = 0;
    int          t_vs = 0;
    logic [63:0] exp_q[$];

    mipi_tx_frame_sched_if bus ();

    mipi_tx_frame_sched #(
        .HRES_PX     (12),
        .PX_PER_BEAT (6),
        .LINES       (2),
        .RSTN_DLY    (4),
        .VS_LEAD     (2),
        .HS_LEAD     (3),
        .HS_TAIL     (2),
        .LINE_GAP    (1),
        .FRAME_GAP   (4)
    ) dut (
        .tx_pixel_clk (clk),
        .rst          (rst),
        .enable       (enable),
        .underrun_clr (underrun_clr),
        .bus          (bus),
        .tx_rstn      (tx_rstn),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_cnt    (frame_cnt),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pixel source: data is the beat index; beats flagged in drop_mask go out invalid
    initial begin
        bus.src_data  = 64'h0;
        bus.src_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.src_data  = 64'(beat_idx);
            bus.src_valid = !drop_mask[beat_idx % 32];
            if (bus.src_ready) begin
                exp_q.push_back(bus.src_valid ? 64'(beat_idx) : 64'h0);
                beat_idx++;
            end
        end
    end

    initial begin : scoreboard
        logic [63:0] exp;
        forever begin
            @(posedge clk); #1;
            if (bus.tx_valid) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL beat_unexpected: tx_data=%h while no beat was pending", bus.tx_data);
                end else begin
                    exp = exp_q.pop_front();
                    n_beats++;
                    if (bus.tx_data !== exp) begin
                        n_err++;
                        $display("FAIL beat_data: got %h expected %h", bus.tx_data, exp);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; underrun_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({tx_rstn, busy, frame_done, underrun, bus.tx_vsync, bus.tx_hsync, bus.tx_valid, bus.src_ready} !== 8'h0) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 00000000",
                     {tx_rstn, busy, frame_done, underrun, bus.tx_vsync, bus.tx_hsync, bus.tx_valid, bus.src_ready});
        end
        n_vec++;
        if (frame_cnt !== 16'h0) begin
            n_err++;
            $display("FAIL reset_frame_cnt: got %h expected 0000", frame_cnt);
        end
        n_vec++;
        if (bus.tx_data !== 64'h0) begin
            n_err++;
            $display("FAIL reset_tx_data: got %h expected 0", bus.tx_data);
        end
    endtask

    // Releases rst and checks tx_rstn at cycle 4, busy at 5, vsync at 6
    task automatic test_startup(input bit force_wrap);
        logic [2:0] exp;
        enable = 1'b1; beat_idx = 0; drop_mask = 32'h0;
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            exp = {k >= 4, k >= 5, k >= 6};
            n_vec++;
            if ({tx_rstn, busy, bus.tx_vsync} !== exp) begin
                n_err++;
                $display("FAIL startup_cycle%0d {rstn,busy,vsync}: got %b expected %b", k, {tx_rstn, busy, bus.tx_vsync}, exp);
            end
            if (k == 5) begin
                t_vs = cyc;
                if (force_wrap) force dut.r_frame_cnt = 16'hFFFF;
            end
            if (k == 6 && force_wrap) release dut.r_frame_cnt;
        end
    endtask

    task automatic test_frame();
        int   hs_run = 0;
        int   nb0 = n_beats;
        logic prev_valid = 1'b0;
        logic done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk); #1;
            if (bus.tx_valid && !prev_valid) begin
                n_vec++;
                if (hs_run !== 3) begin
                    n_err++;
                    $display("FAIL hsync_lead: got %0d hsync-only cycles expected 3", hs_run);
                end
            end
            if (bus.tx_hsync && !bus.tx_valid) hs_run++; else hs_run = 0;
            prev_valid = bus.tx_valid;
            if (frame_done) begin
                done = 1'b1;
                n_vec++;
                if (cyc - t_vs !== 22) begin
                    n_err++;
                    $display("FAIL frame_len: got %0d cycles expected 22", cyc - t_vs);
                end
            end
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL frame_done_timeout: got no pulse expected one within 40 cycles");
        end
        n_vec++;
        if (frame_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL frame_cnt_1: got %0d expected 1", frame_cnt);
        end
        n_vec++;
        if (n_beats - nb0 !== 4) begin
            n_err++;
            $display("FAIL frame_beats: got %0d expected 4", n_beats - nb0);
        end
        n_vec++;
        if (bus.tx_vsync !== 1'b0) begin
            n_err++;
            $display("FAIL vsync_in_frame_gap: got %b expected 0", bus.tx_vsync);
        end
        t_vs = cyc;
    endtask

    task automatic test_back_to_back();
        int   busy_low = 0;
        logic done = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if ({frame_done, bus.tx_vsync, busy} !== 3'b011) begin
            n_err++;
            $display("FAIL b2b_restart {done,vsync,busy}: got %b expected 011", {frame_done, bus.tx_vsync, busy});
        end
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk); #1;
            if (!busy) busy_low++;
            if (frame_done) done = 1'b1;
        end
        n_vec++;
        if (!done || (cyc - t_vs !== 22)) begin
            n_err++;
            $display("FAIL b2b_period: got %0d cycles (seen=%b) expected 22", cyc - t_vs, done);
        end
        n_vec++;
        if (busy_low !== 0) begin
            n_err++;
            $display("FAIL b2b_busy: got %0d idle cycles expected 0", busy_low);
        end
        n_vec++;
        if (frame_cnt !== 16'd2) begin
            n_err++;
            $display("FAIL frame_cnt_2: got %0d expected 2", frame_cnt);
        end
        t_vs = cyc;
        beat_idx = 0;
        drop_mask = 32'hA;
    endtask

    task automatic wait_ready(input string tag);
        for (int k = 0; k < 40 && !bus.src_ready; k++) begin
            @(posedge clk); #1;
        end
        if (!bus.src_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got src_ready=0 expected 1 within 40 cycles", tag);
        end
    endtask

    task automatic test_underrun();
        n_vec++;
        if (underrun !== 1'b0) begin
            n_err++;
            $display("FAIL underrun_init: got %b expected 0", underrun);
        end
        wait_ready("ur_line0");
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_vec++;
        if (underrun !== 1'b1) begin
            n_err++;
            $display("FAIL underrun_set: got %b expected 1", underrun);
        end
        wait_ready("ur_line1");
        underrun_clr = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (underrun !== 1'b0) begin
            n_err++;
            $display("FAIL underrun_clr: got %b expected 0", underrun);
        end
        @(posedge clk); #1;
        n_vec++;
        if (underrun !== 1'b1) begin
            n_err++;
            $display("FAIL underrun_set_wins: got %b expected 1", underrun);
        end
        underrun_clr = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (underrun !== 1'b1) begin
            n_err++;
            $display("FAIL underrun_sticky: got %b expected 1", underrun);
        end
        underrun_clr = 1'b1;
        @(posedge clk); #1;
        underrun_clr = 1'b0;
        n_vec++;
        if (underrun !== 1'b0) begin
            n_err++;
            $display("FAIL underrun_clr_alone: got %b expected 0", underrun);
        end
        drop_mask = 32'h0;
    endtask

    task automatic test_disable();
        int   nb0;
        int   busy_hi = 0;
        logic done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk); #1;
            if (frame_done) done = 1'b1;
        end
        n_vec++;
        if (!done || frame_cnt !== 16'd3) begin
            n_err++;
            $display("FAIL frame_cnt_3: got %0d (seen=%b) expected 3", frame_cnt, done);
        end
        t_vs = cyc;
        nb0 = n_beats;
        wait_ready("dis_active");
        enable = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk); #1;
            if (frame_done) done = 1'b1;
        end
        n_vec++;
        if (!done || (cyc - t_vs !== 22) || frame_cnt !== 16'd4) begin
            n_err++;
            $display("FAIL disable_frame: got len=%0d cnt=%0d seen=%b expected len=22 cnt=4", cyc - t_vs, frame_cnt, done);
        end
        n_vec++;
        if (n_beats - nb0 !== 4) begin
            n_err++;
            $display("FAIL disable_beats: got %0d expected 4", n_beats - nb0);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (busy || bus.tx_vsync) busy_hi++;
        end
        n_vec++;
        if (busy_hi !== 0) begin
            n_err++;
            $display("FAIL disable_idle: got %0d busy/vsync cycles expected 0", busy_hi);
        end
    endtask

    task automatic test_midframe_reset();
        int   pulses = 0;
        logic done = 1'b0;
        enable = 1'b1;
        wait_ready("rst_active");
        for (int k = 0; k < 10 && bus.src_ready; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({tx_rstn, busy, frame_done, underrun, bus.tx_vsync, bus.tx_hsync, bus.tx_valid, bus.src_ready} !== 8'h0
            || frame_cnt !== 16'h0 || bus.tx_data !== 64'h0) begin
            n_err++;
            $display("FAIL midframe_rst: got flags=%b cnt=%h data=%h expected all 0",
                     {tx_rstn, busy, frame_done, underrun, bus.tx_vsync, bus.tx_hsync, bus.tx_valid, bus.src_ready},
                     frame_cnt, bus.tx_data);
        end
        n_vec++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL midframe_pending: got %0d beats pending expected 0", exp_q.size());
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            if (frame_done) pulses++;
        end
        n_vec++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL midframe_no_done: got %0d pulses expected 0", pulses);
        end
        test_startup(1'b1);
        n_vec++;
        if (frame_cnt !== 16'hFFFF) begin
            n_err++;
            $display("FAIL forced_cnt: got %h expected ffff", frame_cnt);
        end
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk); #1;
            if (frame_done) done = 1'b1;
        end
        n_vec++;
        if (!done || (cyc - t_vs !== 22) || frame_cnt !== 16'h0000) begin
            n_err++;
            $display("FAIL cnt_wrap: got cnt=%h len=%0d seen=%b expected cnt=0000 len=22", frame_cnt, cyc - t_vs, done);
        end
    endtask

    initial begin
        test_reset();
        test_startup(1'b0);
        test_frame();
        test_back_to_back();
        test_underrun();
        test_disable();
        test_midframe_reset();
        enable = 1'b0;
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
